// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ word-level requesters.
// Define UART_ARB_GAP_EN to force GAP_CYCLES idle clocks on the line after every frame.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int BITS_PER_WORD = 8,
   parameter int GAP_CYCLES    = 5208
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*BITS_PER_WORD-1:0] req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic                             tx_valid,
   output logic [BITS_PER_WORD-1:0]         tx_data,
   input  logic                             tx_ready,
   input  logic                             tx_done,
   output logic [$clog2(NUM_REQ)-1:0]       grant_id,
   output logic                             busy,
   output logic [15:0]                      frame_count
);

   localparam int IDW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 1) begin : gParamCheck
      $error("uart_tx_arbiter: NUM_REQ must be 2..8 and GAP_CYCLES at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
`ifdef UART_ARB_GAP_EN
      WAIT_DONE,
      GAP
`else
      WAIT_DONE
`endif
   } state_e;

   state_e                   state_q, state_d;
   logic [IDW-1:0]           ptr_q, ptr_d;
   logic [BITS_PER_WORD-1:0] txData_q, txData_d;
   logic [IDW-1:0]           grantId_q, grantId_d;
   logic [15:0]              frameCount_q, frameCount_d;

`ifdef UART_ARB_GAP_EN
   localparam int GCW = $clog2(GAP_CYCLES + 1);
   logic [GCW-1:0]           gapCnt_q, gapCnt_d;
`endif

   logic                     hiFound, loFound, winFound;
   logic [IDW-1:0]           hiIdx, loIdx, winIdx, ptrNext;
   logic [NUM_REQ-1:0]       winOneHot;

   // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index below it.
   always_comb begin
      hiFound = 1'b0;
      loFound = 1'b0;
      hiIdx   = '0;
      loIdx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            if (i >= int'(ptr_q)) begin
               hiFound = 1'b1;
               hiIdx   = IDW'(i);
            end else begin
               loFound = 1'b1;
               loIdx   = IDW'(i);
            end
         end
      end
      winFound          = hiFound | loFound;
      winIdx            = hiFound ? hiIdx : loIdx;
      ptrNext           = (winIdx == IDW'(NUM_REQ - 1)) ? '0 : winIdx + IDW'(1);
      winOneHot         = '0;
      winOneHot[winIdx] = winFound;
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      txData_d     = txData_q;
      grantId_d    = grantId_q;
      frameCount_d = frameCount_q;
`ifdef UART_ARB_GAP_EN
      gapCnt_d     = gapCnt_q;
`endif
      req_ready    = '0;
      unique case (state_q)
         IDLE: begin
            // Gated by rstn so no accept strobe escapes while reset is held.
            req_ready = rstn ? winOneHot : '0;
            if (winFound) begin
               txData_d  = req_data[winIdx*BITS_PER_WORD +: BITS_PER_WORD];
               grantId_d = winIdx;
               ptr_d     = ptrNext;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (tx_ready) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               frameCount_d = frameCount_q + 16'd1;
`ifdef UART_ARB_GAP_EN
               gapCnt_d     = '0;
               state_d      = GAP;
`else
               state_d      = IDLE;
`endif
            end
         end
`ifdef UART_ARB_GAP_EN
         GAP: begin
            if (gapCnt_q == GCW'(GAP_CYCLES - 1)) state_d = IDLE;
            else                                  gapCnt_d = gapCnt_q + GCW'(1);
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         txData_q     <= '0;
         grantId_q    <= '0;
         frameCount_q <= '0;
`ifdef UART_ARB_GAP_EN
         gapCnt_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         txData_q     <= txData_d;
         grantId_q    <= grantId_d;
         frameCount_q <= frameCount_d;
`ifdef UART_ARB_GAP_EN
         gapCnt_q     <= gapCnt_d;
`endif
      end
   end

   assign tx_valid    = (state_q == ISSUE);
   assign busy        = (state_q != IDLE);
   assign tx_data     = txData_q;
   assign grant_id    = grantId_q;
   assign frame_count = frameCount_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// compared against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int NumReq      = 4;
   localparam int BitsPerWord = 8;
   localparam int GapCycles   = 16;
`ifdef UART_ARB_GAP_EN
   localparam int ExpGap      = GapCycles;
`else
   localparam int ExpGap      = 0;
`endif

   logic                            clk = 1'b0;
   logic                            rstn = 1'b0;
   logic [NumReq-1:0]               reqValid = '0;
   logic [NumReq*BitsPerWord-1:0]   reqData = '0;
   logic [NumReq-1:0]               reqReady;
   logic                            txValid;
   logic [BitsPerWord-1:0]          txData;
   logic                            txReady = 1'b0;
   logic                            txDone = 1'b0;
   logic [$clog2(NumReq)-1:0]       grantId;
   logic                            busy;
   logic [15:0]                     frameCount;

   int vectors = 0;
   int miscompares = 0;
   int modelPtr = 0;
   int modelCount = 0;

   uart_tx_arbiter #(
      .NUM_REQ(NumReq),
      .BITS_PER_WORD(BitsPerWord),
      .GAP_CYCLES(GapCycles)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .req_valid(reqValid),
      .req_data(reqData),
      .req_ready(reqReady),
      .tx_valid(txValid),
      .tx_data(txData),
      .tx_ready(txReady),
      .tx_done(txDone),
      .grant_id(grantId),
      .busy(busy),
      .frame_count(frameCount)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference arbitration: scan ptr, ptr+1, ... modulo NumReq for the first valid requester.
   function automatic int pickWinner(input logic [NumReq-1:0] v, input int p);
      for (int k = 0; k < NumReq; k++) begin
         if (v[(p + k) % NumReq]) return (p + k) % NumReq;
      end
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   // One complete frame: arbitration, optional TX stall, frame time, then tx_done or an abort by reset.
   task automatic applyStimulus(input logic [NumReq-1:0] valid, input logic [31:0] words,
                                input int stall, input int frameLen, input bit abortRst,
                                output int granted);
      int w;
      int waitCnt;
      int n;
      logic [BitsPerWord-1:0] expData;
      granted  = -1;
      reqValid = valid;
      reqData  = words;
      txReady  = 1'b0;
      txDone   = 1'b0;
      w        = pickWinner(valid, modelPtr);
      expData  = words[w*BitsPerWord +: BitsPerWord];
      waitCnt  = 0;
      settle();
      while (reqReady == '0 && waitCnt < 40) begin
         tick();
         settle();
         waitCnt++;
      end
      if (reqReady == '0) begin
         checkOutput("grantTimeout", 32'd0, 32'd1);
         return;
      end
      checkOutput("reqReady", 32'(reqReady), 32'(1) << w);
      tick();
      reqValid[w] = 1'b0;
      modelPtr    = (w + 1) % NumReq;
      for (int s = 0; s <= stall; s++) begin
         txReady = (s == stall);
         txDone  = 1'($urandom_range(0, 1));
         settle();
         if (s == 0) begin
            granted = int'(grantId);
            checkOutput("grantId", 32'(grantId), 32'(w));
         end
         checkOutput("txValid", 32'(txValid), 32'd1);
         checkOutput("txData", 32'(txData), 32'(expData));
         checkOutput("noReadyIssue", 32'(reqReady), 32'd0);
         tick();
      end
      txReady = 1'($urandom_range(0, 1));
      txDone  = 1'b0;
      for (int f = 0; f < frameLen; f++) begin
         settle();
         checkOutput("txValidWait", 32'(txValid), 32'd0);
         checkOutput("busyWait", 32'(busy), 32'd1);
         checkOutput("noReadyWait", 32'(reqReady), 32'd0);
         checkOutput("countWait", 32'(frameCount), 32'(modelCount));
         tick();
         txReady = 1'($urandom_range(0, 1));
      end
      if (abortRst) begin
         rstn = 1'b0;
         #1;
         checkOutput("rstTxValid", 32'(txValid), 32'd0);
         checkOutput("rstTxData", 32'(txData), 32'd0);
         checkOutput("rstGrant", 32'(grantId), 32'd0);
         checkOutput("rstBusy", 32'(busy), 32'd0);
         checkOutput("rstCount", 32'(frameCount), 32'd0);
         checkOutput("rstReady", 32'(reqReady), 32'd0);
         modelCount = 0;
         modelPtr   = 0;
         txReady    = 1'b0;
         tick();
         rstn     = 1'b1;
         reqValid = '0;
         txDone   = 1'b1;
         tick();
         txDone = 1'b0;
         settle();
         checkOutput("strayDoneCount", 32'(frameCount), 32'd0);
         checkOutput("strayDoneBusy", 32'(busy), 32'd0);
         return;
      end
      txDone  = 1'b1;
      txReady = 1'b0;
      tick();
      txDone     = 1'b0;
      modelCount = (modelCount + 1) & 16'hFFFF;
      settle();
      checkOutput("frameCount", 32'(frameCount), 32'(modelCount));
      n = 0;
      while (busy === 1'b1 && n < ExpGap + 10) begin
         checkOutput("gapNoReady", 32'(reqReady), 32'd0);
         tick();
         settle();
         n++;
      end
      checkOutput("gapLen", 32'(n), 32'(ExpGap));
   endtask

   initial begin
      int g;
      int order[5] = '{0, 1, 2, 3, 0};
      logic [NumReq-1:0] v;

      reqValid = '1;
      repeat (3) @(posedge clk);
      #1;
      settle();
      checkOutput("resetReady", 32'(reqReady), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetTxValid", 32'(txValid), 32'd0);
      checkOutput("resetCount", 32'(frameCount), 32'd0);
      checkOutput("resetGrant", 32'(grantId), 32'd0);
      checkOutput("resetTxData", 32'(txData), 32'd0);
      reqValid = '0;
      tick();
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 32'hA3A2A1A0, 0, 3, 1'b0, g);
         checkOutput("rrOrder", 32'(g), 32'(order[i]));
      end

      applyStimulus(4'b0010, 32'h00003500, 0, 5, 1'b0, g);
      checkOutput("singleGrant", 32'(g), 32'd1);
      checkOutput("singleCount", 32'(frameCount), 32'd6);

      applyStimulus(4'b0100, $urandom, 1, 2, 1'b0, g);
      checkOutput("ptrGrant2", 32'(g), 32'd2);
      applyStimulus(4'b1001, $urandom, 0, 2, 1'b0, g);
      checkOutput("ptrGrant3", 32'(g), 32'd3);
      applyStimulus(4'b1001, $urandom, 0, 2, 1'b0, g);
      checkOutput("ptrGrant0", 32'(g), 32'd0);

      applyStimulus(4'b0001, 32'h5A5A5A5A, 100, 4, 1'b0, g);
      checkOutput("stallGrant", 32'(g), 32'd0);

      applyStimulus(4'b1000, $urandom, 2, 6, 1'b1, g);
      checkOutput("abortGrant", 32'(g), 32'd3);

      for (int r = 0; r < 40; r++) begin
         v = NumReq'($urandom_range(1, (1 << NumReq) - 1));
         applyStimulus(v, $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 8)), 1'b0, g);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
